// File: rtl/mtr_duty_seq.sv
// Purpose: sequences left/right PWM duty from signed speed commands (clip, slew-limit, period-aligned update).
// Latency: command capture 1 clk; duty steps land on the edge closing each PWM period (visible from cnt=0).
// Backpressure: none; cmd_vld is a strobe and the last command before a period boundary wins.
module mtr_duty_seq #(
    parameter int          PERIOD    = 2048,
    parameter int          SLEW_STEP = 16,
    parameter logic [10:0] MID       = 11'h400,
    parameter int          MAX_SPD   = 1000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        en,
    input  logic        cmd_vld,
    input  logic [10:0] lft_spd,
    input  logic [10:0] rght_spd,
    output logic [10:0] lft_duty,
    output logic [10:0] rght_duty,
    output logic        pwm_en,
    output logic        period_tick,
    output logic        settled
);

    localparam logic [10:0]        CNT_LAST = 11'(PERIOD - 1);
    localparam logic [10:0]        CNT_PRE  = 11'(PERIOD - 2);
    localparam logic signed [11:0] SPD_HI   = 12'(MAX_SPD);
    localparam logic signed [11:0] SPD_LO   = 12'(-MAX_SPD);
    localparam logic signed [11:0] STEP_P   = 12'(SLEW_STEP);
    localparam logic signed [11:0] STEP_N   = 12'(-SLEW_STEP);
    localparam logic [10:0]        STEP_U   = 11'(SLEW_STEP);

    typedef enum logic [1:0] {
        S_OFF   = 2'd0,
        S_RUN   = 2'd1,
        S_BRAKE = 2'd2
    } state_t;

    state_t      state;
    logic [10:0] cnt;
    logic [10:0] lft_tgt;
    logic [10:0] rght_tgt;

    // Clip a signed speed to +/-MAX_SPD and shift it to offset-binary around MID.
    // After the clip the sum always fits in 11 bits, so the low bits are exact.
    function automatic logic [10:0] spd_to_tgt(input logic [10:0] spd);
        logic signed [11:0] s;
        s = {spd[10], spd};
        if (s > SPD_HI) begin
            s = SPD_HI;
        end else if (s < SPD_LO) begin
            s = SPD_LO;
        end
        return MID + s[10:0];
    endfunction

    // One slew step: jump to the target when within SLEW_STEP, else move SLEW_STEP toward it.
    function automatic logic [10:0] slew(input logic [10:0] duty, input logic [10:0] tgt);
        logic signed [11:0] diff;
        diff = $signed({1'b0, tgt}) - $signed({1'b0, duty});
        if (diff > STEP_P) begin
            return duty + STEP_U;
        end else if (diff < STEP_N) begin
            return duty - STEP_U;
        end else begin
            return tgt;
        end
    endfunction

    // Free-running period counter; the tick is registered so it is high exactly while cnt==PERIOD-1.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt         <= '0;
            period_tick <= 1'b0;
        end else begin
            cnt         <= (cnt == CNT_LAST) ? 11'd0 : cnt + 11'd1;
            period_tick <= (cnt == CNT_PRE);
        end
    end

    // Enable sequencing, command capture and period-aligned duty slewing with registered outputs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= S_OFF;
            lft_duty  <= MID;
            rght_duty <= MID;
            lft_tgt   <= MID;
            rght_tgt  <= MID;
            pwm_en    <= 1'b0;
            settled   <= 1'b1;
        end else begin
            settled <= (lft_duty == lft_tgt) && (rght_duty == rght_tgt);
            case (state)
                S_OFF: begin
                    lft_duty  <= MID;
                    rght_duty <= MID;
                    lft_tgt   <= MID;
                    rght_tgt  <= MID;
                    pwm_en    <= 1'b0;
                    if (en) begin
                        state  <= S_RUN;
                        pwm_en <= 1'b1;
                    end
                end
                S_RUN: begin
                    // The step below reads the pre-capture target, so a command
                    // coinciding with a tick only takes effect on the following tick.
                    if (cmd_vld) begin
                        lft_tgt  <= spd_to_tgt(lft_spd);
                        rght_tgt <= spd_to_tgt(rght_spd);
                    end
                    if (period_tick) begin
                        lft_duty  <= slew(lft_duty, lft_tgt);
                        rght_duty <= slew(rght_duty, rght_tgt);
                    end
                    if (!en) begin
                        state <= S_BRAKE;
                    end
                end
                S_BRAKE: begin
                    // Ramp toward MID directly so the first braking step never
                    // chases a stale running target.
                    lft_tgt  <= MID;
                    rght_tgt <= MID;
                    if (period_tick) begin
                        lft_duty  <= slew(lft_duty, MID);
                        rght_duty <= slew(rght_duty, MID);
                    end
                    if (en) begin
                        state <= S_RUN;
                    end else if ((lft_duty == MID) && (rght_duty == MID)) begin
                        state  <= S_OFF;
                        pwm_en <= 1'b0;
                    end
                end
                default: begin
                    state  <= S_OFF;
                    pwm_en <= 1'b0;
                end
            endcase
        end
    end

endmodule
